multi_counter: RTL and testbench

Parametrised bank of `CHANNELS` independent up/down counters, each `WIDTH` bits wide, sharing one clock and reset. Each channel has its own:
- enable and direction;
- synchronous load;
- wrap or saturate mode.

All channels share a programmable terminal value `limit`. The block is the general-purpose event and timing counter for the lab datapath. Each channel raises a registered terminal-count pulse for downstream sequencing logic.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_chan.sv | 61 ++++++
 rtl/multi_counter.sv | 45 ++++
 tb/tb_multi_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the multi-channel up/down counter.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

endpackage

// File: rtl/counter_chan.sv
// One counter channel: count/tc registers with load > enable > hold priority
// and wrap/saturate handling at 0 and at the shared limit.
module counter_chan
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  cnt_mode_e        mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            if (dir == CNT_UP) begin
                // ">= limit" also catches a count left above a freshly lowered limit
                if (count_q < limit) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = (mode == CNT_SAT) ? limit : '0;
                    tc_d    = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d = (mode == CNT_SAT) ? '0 : limit;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: rtl/multi_counter.sv
// Bank of CHANNELS independent up/down counters sharing clock, reset and limit.
// Per-channel vectors are packed with channel i at bits [i*WIDTH +: WIDTH].
module multi_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0]          limit,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc
);

    if (WIDTH < 2) begin : g_bad_width
        $error("multi_counter: WIDTH must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_counter: CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        counter_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .dir     (dir[i]),
            .mode    (cnt_mode_e'(mode[i])),
            .load    (load[i]),
            .load_val(load_val[i*WIDTH +: WIDTH]),
            .limit   (limit),
            .count   (count[i*WIDTH +: WIDTH]),
            .tc      (tc[i])
        );
    end

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: directed scenarios plus a long random
// run checked cycle by cycle against a scoreboard fed by a reference model.
module tb_multi_counter;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [C-1:0]   en, dir, mode, load;
    logic [C*W-1:0] load_val;
    logic [W-1:0]   limit;
    logic [C*W-1:0] count;
    logic [C-1:0]   tc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [C*W-1:0] count;
        logic [C-1:0]   tc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    multi_counter #(
        .WIDTH   (W),
        .CHANNELS(C)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .count   (count),
        .tc      (tc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] cnt(int i);
        return count[i*W +: W];
    endfunction

    task automatic set_lv(int i, int v);
        load_val[i*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; dir = '1; mode = '0; load = '1; limit = 8'd255;
        load_val = {8'd40, 8'd30, 8'd20, 8'd10};
        tick();
        tick();
        n_checks++;
        if (count !== '0 || tc !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: count=%h tc=%b, want 0/0", count, tc);
        end
        rst = 1'b0; load = '0; en = 4'b0001; dir = 4'b0001;
        tick();
        n_checks++;
        if (count !== 32'h0000_0001 || tc !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: count=%h tc=%b, want 00000001/0000", count, tc);
        end
    endtask

    task automatic test_wrap_up();
        int seq [7] = '{1, 2, 3, 4, 5, 0, 1};
        int tcs [7] = '{0, 0, 0, 0, 0, 1, 0};
        limit = 8'd5; en = '0; load = 4'b0001; set_lv(0, 0);
        tick();
        load = '0; en = 4'b0001; dir = 4'b0001; mode = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++;
            if (cnt(0) !== W'(seq[k]) || tc[0] !== 1'(tcs[k])) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: count0=%0d tc0=%b, want %0d/%0d",
                         k, cnt(0), tc[0], seq[k], tcs[k]);
            end
        end
        en = '0;
    endtask

    task automatic test_sat_down();
        int seq [4] = '{1, 0, 0, 0};
        int tcs [4] = '{0, 0, 1, 1};
        load = 4'b0010; set_lv(1, 2);
        tick();
        load = '0; en = 4'b0010; dir[1] = 1'b0; mode[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (cnt(1) !== W'(seq[k]) || tc[1] !== 1'(tcs[k])) begin
                n_fail++;
                $display("FAIL sat_down[%0d]: count1=%0d tc1=%b, want %0d/%0d",
                         k, cnt(1), tc[1], seq[k], tcs[k]);
            end
        end
        mode[1] = 1'b0;
        tick();
        n_checks++;
        if (cnt(1) !== 8'd5 || tc[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_down: count1=%0d tc1=%b, want 5/1", cnt(1), tc[1]);
        end
        en = '0;
        tick();
        n_checks++;
        if (cnt(1) !== 8'd5 || tc[1] !== 1'b0 || cnt(0) !== 8'd1) begin
            n_fail++;
            $display("FAIL hold: count1=%0d tc1=%b count0=%0d, want 5/0/1", cnt(1), tc[1], cnt(0));
        end
    endtask

    task automatic test_load();
        limit = 8'd10; en = '0; load = 4'b0001; set_lv(0, 200);
        tick();
        n_checks++;
        if (cnt(0) !== 8'd10 || tc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: count0=%0d tc0=%b, want 10/0", cnt(0), tc[0]);
        end
        // At the limit, a step would wrap with tc; the load must win instead
        load = 4'b0001; set_lv(0, 3); en = 4'b0001; dir[0] = 1'b1; mode[0] = 1'b0;
        tick();
        n_checks++;
        if (cnt(0) !== 8'd3 || tc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority: count0=%0d tc0=%b, want 3/0", cnt(0), tc[0]);
        end
        load = '0; en = '0;
    endtask

    task automatic test_limit_drop();
        int md  [3] = '{0, 1, 0};
        int dr  [3] = '{1, 1, 0};
        int ec  [3] = '{0, 4, 8};
        int et  [3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            limit = 8'd10; en = '0; load = 4'b0100; set_lv(2, 9);
            tick();
            n_checks++;
            if (cnt(2) !== 8'd9) begin
                n_fail++;
                $display("FAIL limit_drop_setup[%0d]: count2=%0d, want 9", k, cnt(2));
            end
            limit = 8'd4; load = '0; en = 4'b0100; dir[2] = 1'(dr[k]); mode[2] = 1'(md[k]);
            tick();
            n_checks++;
            if (cnt(2) !== W'(ec[k]) || tc[2] !== 1'(et[k])) begin
                n_fail++;
                $display("FAIL limit_drop[%0d]: count2=%0d tc2=%b, want %0d/%0d",
                         k, cnt(2), tc[2], ec[k], et[k]);
            end
        end
        en = '0;
    endtask

    task automatic test_random();
        int   m [C];
        bit   t [C];
        exp_t e, got;
        for (int c = 0; c < C; c++) begin
            m[c] = 0;
            t[c] = 1'b0;
        end
        for (int i = 0; i < 10000; i++) begin
            if (i < 4000) begin
                if (i % 40 == 0) limit = W'($urandom_range(0, 255));
            end else if (i < 6000) begin
                limit = 8'd0;
            end else begin
                limit = 8'd255;
            end
            rst = (i == 0) || ($urandom_range(0, 199) == 0);
            for (int c = 0; c < C; c++) begin
                if (i % 16 == 0) begin
                    dir[c]  = 1'($urandom_range(0, 1));
                    mode[c] = 1'($urandom_range(0, 1));
                end
                en[c]   = ($urandom_range(0, 3) != 0);
                load[c] = ($urandom_range(0, 19) == 0);
                if (i >= 6000 && $urandom_range(0, 1) == 1) set_lv(c, $urandom_range(240, 255));
                else set_lv(c, $urandom_range(0, 255));
            end
            for (int c = 0; c < C; c++) begin
                int lv  = int'(load_val[c*W +: W]);
                int lim = int'(limit);
                if (rst) begin
                    m[c] = 0; t[c] = 1'b0;
                end else if (load[c]) begin
                    m[c] = (lv < lim) ? lv : lim; t[c] = 1'b0;
                end else if (!en[c]) begin
                    t[c] = 1'b0;
                end else if (dir[c]) begin
                    t[c] = (m[c] >= lim);
                    if (t[c]) m[c] = mode[c] ? lim : 0;
                    else m[c] = m[c] + 1;
                end else begin
                    t[c] = (m[c] == 0);
                    if (t[c]) m[c] = mode[c] ? 0 : lim;
                    else m[c] = m[c] - 1;
                end
                e.count[c*W +: W] = W'(m[c]);
                e.tc[c]           = t[c];
            end
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (count !== got.count || tc !== got.tc) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%h tc=%b, want %h/%b",
                         i, count, tc, got.count, got.tc);
            end
        end
        rst = 1'b0; en = '0; load = '0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load();
        test_limit_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
